// File: rtl/ks_serial_adder_pkg.sv
// Shared definitions for the slice-serial Kogge-Stone adder: slice width,
// FSM encoding and size helpers.
package ks_serial_adder_pkg;

  localparam int SLICE_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int num_slices(input int w, input int slice);
    return w / slice;
  endfunction

  // The slice index register is never narrower than one bit.
  function automatic int idx_width(input int ns);
    return (ns <= 1) ? 1 : $clog2(ns);
  endfunction

endpackage

// File: rtl/ks_serial_adder_slice.sv
// Purely combinational SLICE-bit Kogge-Stone adder. The carry-in is folded
// in after the prefix tree.
module ks_slice_adder
  import ks_serial_adder_pkg::*;
#(
  parameter int SLICE = SLICE_DEF
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);

  localparam int LV = $clog2(SLICE);

  // After level l, g/p at bit i cover the span of bits i-(2^l)+1 .. i.
  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    for (genvar i = 0; i < SLICE; i++) begin : g_bit
      if (l == 0) begin : g_leaf
        assign g[i] = x[i] & y[i];
        assign p[i] = x[i] ^ y[i];
      end else if (i >= (1 << (l - 1))) begin : g_merge
        assign g[i] = g_lvl[l-1].g[i] | (g_lvl[l-1].p[i] & g_lvl[l-1].g[i-(1<<(l-1))]);
        assign p[i] = g_lvl[l-1].p[i] & g_lvl[l-1].p[i-(1<<(l-1))];
      end else begin : g_pass
        assign g[i] = g_lvl[l-1].g[i];
        assign p[i] = g_lvl[l-1].p[i];
      end
    end
  end

  logic [SLICE:0] c;

  assign c  = {g_lvl[LV].g | (g_lvl[LV].p & {SLICE{ci}}), ci};
  assign s  = g_lvl[0].p ^ c[SLICE-1:0];
  assign co = c[SLICE];

endmodule

// File: rtl/ks_serial_adder.sv
// Sequential wide adder: feeds one SLICE-bit Kogge-Stone slice per cycle,
// least-significant first, chaining the carry through a register.
module ks_serial_adder
  import ks_serial_adder_pkg::*;
#(
  parameter int W     = 32,
  parameter int SLICE = SLICE_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   sum,
  output logic         busy
);

  if (W <= 0 || (W % SLICE) != 0) begin : g_bad_width
    $error("ks_serial_adder: W must be a positive multiple of SLICE");
  end

  localparam int NS = num_slices(W, SLICE);
  localparam int IW = idx_width(NS);
  localparam logic [IW-1:0] IDX_LAST = IW'(NS - 1);

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W:0]     sum_q, sum_d;

  logic [SLICE-1:0] sl_x, sl_y, sl_s;
  logic             sl_co;

  assign sl_x = a_q[idx_q*SLICE +: SLICE];
  assign sl_y = b_q[idx_q*SLICE +: SLICE];

  ks_slice_adder #(.SLICE(SLICE)) u_slice (
    .x  (sl_x),
    .y  (sl_y),
    .ci (carry_q),
    .s  (sl_s),
    .co (sl_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[idx_q*SLICE +: SLICE] = sl_s;
        carry_d = sl_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          sum_d[W] = sl_co;
          idx_d    = '0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  // Handshake outputs are pure decodes of the registered state.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum       = sum_q;

endmodule

// File: tb/tb_ks_serial_adder.sv
// Self-checking bench for ks_serial_adder: directed corner cases plus random
// operands with random result backpressure, checked against a + b + cin.
module tb_ks_serial_adder;

  localparam int W     = 32;
  localparam int SLICE = 4;
  localparam int NS    = W / SLICE;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W:0]   sum;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ks_serial_adder #(.W(W), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    a        = $urandom;
    b        = $urandom;
    cin      = 1'($urandom);
    in_valid = 1'($urandom);
  endtask

  // One full operation: accept, disturb inputs during RUN, hold DONE for
  // 'stall' cycles, then consume.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_c, input int stall);
    logic [W:0] exp;
    int lat;
    exp = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_c};
    a = op_a; b = op_b; cin = op_c; in_valid = 1'b1;
    out_ready = 1'($urandom);
    chk("rdy_idle", in_ready, 1);
    step();
    chk("busy_acc", busy, 1);
    lat = 0;
    while (!out_valid && lat < 4 * NS) begin
      scramble();
      out_ready = 1'($urandom);
      step();
      lat++;
    end
    chk("latency", lat, NS);
    chk("sum", sum, exp);
    chk("rdy_done", in_ready, 0);
    out_ready = 1'b0;
    for (int k = 0; k < stall; k++) begin
      scramble();
      step();
      chk("hold_sum", sum, exp);
      chk("hold_vld", out_valid, 1);
      chk("hold_rdy", in_ready, 0);
      chk("hold_busy", busy, 1);
    end
    out_ready = 1'b1;
    step();
    chk("vld_drop", out_valid, 0);
    chk("rdy_back", in_ready, 1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_rdy", in_ready, 1);
    chk("rst_vld", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    rst_n = 1'b1;
    step();

    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0);
    run_op(32'h00000000, 32'h00000000, 1'b1, 0);
    run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 5);
    run_op(32'h00000000, 32'h00000000, 1'b0, 1);

    // Abort an operation while the fourth slice is pending.
    a = 32'hDEADBEEF; b = 32'hCAFEF00D; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_vld", out_valid, 0);
    chk("abort_sum", sum, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rdy", in_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_sum", sum, 0);
    run_op(32'd5, 32'd7, 1'b0, 0);

    for (int n = 0; n < 2000; n++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (n % 7 == 0) rb = ~ra;
      run_op(ra, rb, 1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
